// File: rtl/control_pkg.sv
// control_pkg -- shared definitions for the control unit.
//   state_e     : FSM state encoding
//   OP_*        : two-bit instruction opcodes
//   REG_A/REG_B : one-bit register-select values for instr_dst / instr_src
package control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDI  = 3'd1,
        ST_ADD1 = 3'd2,
        ST_ADD2 = 3'd3,
        ST_MV   = 3'd4,
        ST_ILL  = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_MV   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic REG_A = 1'b0;
    localparam logic REG_B = 1'b1;

endpackage

// File: rtl/retire_counter.sv
// retire_counter -- free-running count of retired instructions.
//   clock : rising-edge clock
//   clear : synchronous active-high clear (wins over en)
//   en    : increment on this edge
//   count : current count, wraps from all-ones to zero
module retire_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Plain modular increment: wrapping is the intended behaviour.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// control_unit -- sequencer for a two-register (A/B) datapath with an adder
// and a result register Z.
//   clock, clear             : clock and synchronous active-high reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr_op/dst/src/imm     : instruction fields, captured on acceptance
//   RAout/RBout/RZout        : bus-drive strobes (at most one per cycle)
//   RAin/RBin/RZin           : register-load strobes
//   AddImmediate             : adder immediate (ADD1 only, else 0)
//   RegisterAImmediate       : register-A load value (LDI only, else 0)
//   done, illegal            : one-cycle completion / drop pulses
//   halted                   : HALT has executed; sticky until clear
//   retired                  : count of completed legal instructions
module control_unit
    import control_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic             instr_dst,
    input  logic             instr_src,
    input  logic [7:0]       instr_imm,
    output logic             RAout,
    output logic             RBout,
    output logic             RZout,
    output logic             RAin,
    output logic             RBin,
    output logic             RZin,
    output logic [7:0]       AddImmediate,
    output logic [7:0]       RegisterAImmediate,
    output logic             done,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e     state_q, state_d;
    logic       dst_q, dst_d;
    logic       src_q, src_d;
    logic [7:0] imm_q, imm_d;
    // High only during the first HALT cycle, so done pulses once on entry.
    logic       halt_entry_q, halt_entry_d;

    // The opcode itself is not stored: the execute state already encodes it.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d            = state_q;
        dst_d              = dst_q;
        src_d              = src_q;
        imm_d              = imm_q;
        halt_entry_d       = 1'b0;
        instr_ready        = 1'b0;
        RAout              = 1'b0;
        RBout              = 1'b0;
        RZout              = 1'b0;
        RAin               = 1'b0;
        RBin               = 1'b0;
        RZin               = 1'b0;
        AddImmediate       = 8'h00;
        RegisterAImmediate = 8'h00;
        done               = 1'b0;
        illegal            = 1'b0;
        halted             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    dst_d = instr_dst;
                    src_d = instr_src;
                    imm_d = instr_imm;
                    unique case (instr_op)
                        OP_LDI:  state_d = (instr_dst == REG_A) ? ST_LDI : ST_ILL;
                        OP_ADDI: state_d = ST_ADD1;
                        OP_MV:   state_d = ST_MV;
                        default: begin
                            state_d      = ST_HALT;
                            halt_entry_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_LDI: begin
                RAin               = 1'b1;
                RegisterAImmediate = imm_q;
                done               = 1'b1;
                state_d            = ST_IDLE;
            end

            ST_ADD1: begin
                if (src_q == REG_A) RAout = 1'b1;
                else                RBout = 1'b1;
                AddImmediate = imm_q;
                RZin         = 1'b1;
                state_d      = ST_ADD2;
            end

            ST_ADD2: begin
                RZout = 1'b1;
                if (dst_q == REG_A) RAin = 1'b1;
                else                RBin = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            ST_MV: begin
                if (src_q == REG_A) RAout = 1'b1;
                else                RBout = 1'b1;
                if (dst_q == REG_A) RAin = 1'b1;
                else                RBin = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            ST_ILL: begin
                illegal = 1'b1;
                state_d = ST_IDLE;
            end

            ST_HALT: begin
                halted = 1'b1;
                done   = halt_entry_q;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the latched instruction fields are cleared along with the state so
    // that nothing observable depends on stale pre-reset values.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            dst_q        <= 1'b0;
            src_q        <= 1'b0;
            imm_q        <= 8'h00;
            halt_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            imm_q        <= imm_d;
            halt_entry_q <= halt_entry_d;
        end
    end

    // done is high exactly in the final execute cycle of a legal instruction.
    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clock (clock),
        .clear (clear),
        .en    (done),
        .count (retired)
    );

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the retired-instruction counter.
REQ-002 SHALL have port clock  input  1: the single clock; all state changes on rising edge.
REQ-003 SHALL have port clear  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port instr_valid  input  1: an instruction is offered.
REQ-005 SHALL have port instr_ready  output  1: the unit can accept an instruction.
REQ-006 SHALL have port instr_op  input  2: opcode; 00 LDI, 01 ADDI, 10 MV, 11 HALT.
REQ-007 SHALL have port instr_dst  input  1: destination register; 0=A, 1=B.
REQ-008 SHALL have port instr_src  input  1: source register; 0=A, 1=B.
REQ-009 SHALL have port instr_imm  input  8: immediate operand.
REQ-010 SHALL have port RAout, RBout, RZout  output  1 each: datapath bus-drive strobes.
REQ-011 SHALL have port RAin, RBin, RZin  output  1 each: datapath register-load strobes.
REQ-012 SHALL have port AddImmediate  output  8: adder immediate operand.
REQ-013 SHALL have port RegisterAImmediate  output  8: register-A load immediate.
REQ-014 SHALL have port done  output  1: one-cycle pulse in the final execute cycle.
REQ-015 SHALL have port illegal  output  1: one-cycle pulse when an illegal instruction is dropped.
REQ-016 SHALL have port halted  output  1: HALT has been executed.
REQ-017 SHALL have port retired  output  CNT_W: count of completed legal instructions.

Function
REQ-018 SHALL implement FSM states IDLE, LDI, ADD1, ADD2, MV, ILL, HALT.
REQ-019 SHALL accept on a rising edge where instr_valid && instr_ready, latch op/dst/src/imm, and move to the execute state on that edge.
REQ-020 SHALL drive instr_ready=1 only in IDLE; instr_* are ignored outside IDLE.
REQ-021 SHALL drive all strobes, AddImmediate and RegisterAImmediate only from the state and latched fields; there is no combinational path from instr_* to outputs.
REQ-022 LDI with dst=A: one cycle, RAin=1, RegisterAImmediate=imm; then IDLE.
REQ-023 LDI with dst=B: enters ILL for one cycle; illegal=1, no strobes, retired unchanged; then IDLE.
REQ-024 ADDI: ADD1 drives the src out-strobe, AddImmediate=imm and RZin=1; ADD2 drives RZout=1 and the dst in-strobe; then IDLE.
REQ-025 MV: one cycle driving the src out-strobe and the dst in-strobe; src==dst is legal and executes normally.
REQ-026 HALT: enters HALT, sets halted=1 and done=1 for its entry cycle, increments retired once, and stays in HALT until clear.
REQ-027 SHALL keep at most one out-strobe asserted in any cycle.
REQ-028 SHALL drive AddImmediate and RegisterAImmediate to 0 in every cycle not listed in REQ-022/024.
REQ-029 SHALL assert done in the final execute cycle of each legal instruction; retired increments on that cycle's closing edge.
REQ-030 retired SHALL wrap from 2^CNT_W-1 to 0 without saturating.
REQ-031 Back-to-back issue: the earliest next acceptance is the edge that returns to IDLE plus one cycle (LDI/MV throughput 1 per 2 cycles; ADDI 1 per 3).

Reset
REQ-032 clear=1 on a rising edge SHALL force IDLE from any state, including mid-ADDI and HALT.
REQ-033 During and after reset, all strobes, immediates, done, illegal and halted SHALL be 0, and retired SHALL be 0.
REQ-034 clear SHALL take priority over a simultaneous instr_valid; that instruction is not accepted.

Structure
REQ-035 State encodings, opcode constants (OP_LDI, OP_ADDI, OP_MV, OP_HALT) and register-select constants SHALL live in a shared package, control_pkg.
REQ-036 The retired counter SHALL be one sub-module, retire_counter (enable, synchronous clear, wrap).

Verification
REQ-037 LDI A,5 after reset: RAin=1 and RegisterAImmediate=0x05 for exactly one cycle; done=1; retired=1.
REQ-038 ADDI B,A,5: cycle 1 RAout=RZin=1 with AddImmediate=0x05; cycle 2 RZout=RBin=1; instr_ready low for 2 cycles; retired +1.
REQ-039 LDI B,7: illegal=1 for one cycle, no strobes, retired unchanged, instr_ready back high next cycle.
REQ-040 clear asserted during ADD1 of ADDI A,B,3: ADD2 never occurs; next cycle is IDLE with all outputs 0 and retired=0.
REQ-041 With CNT_W=2, issue 5 MV A,B: retired sequence 1,2,3,0,1.
REQ-042 HALT, then instr_valid held high with MV: halted=1 and instr_ready=0 until clear; no strobes.
